dpram_port_client: RTL

Initiator side of one DPRAM port. Accepts read/write commands on a valid/ready request channel, drives the RAM port pins (`en`, `wr`, `addr`, `wdata`) and captures the synchronous read data. Read data is returned on a valid/ready response channel through a small credit-managed buffer. One instance sits in front of each DPRAM port (A or B) used by a mesh node's local memory agent.

---
 rtl/dpram_pkg.sv | 15 +
 rtl/dpram_port_client_if.sv | 32 +++
 rtl/dpram_rsp_fifo.sv | 85 ++++++++
 rtl/dpram_port_client.sv | 91 +++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// dpram_pkg: definitions shared by the DPRAM port agents of a mesh node.
//   RAM_OP_READ / RAM_OP_WRITE : encoding of the DPRAM per-port `wr` pin
//                                (1 = read, 0 = write).
//   addr_width(depth)          : address width for a RAM of `depth` words.
package dpram_pkg;

    localparam logic RAM_OP_READ  = 1'b1;
    localparam logic RAM_OP_WRITE = 1'b0;

    // A single-word RAM still needs a 1-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dpram_port_client_if.sv
// dpram_port_client_if: request/response channels of one DPRAM port client.
//   req_valid/req_ready/req_write/req_addr/req_wdata : command channel
//   rsp_valid/rsp_ready/rsp_data                     : response channel
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until the transfer;
// ready may change freely and carries no obligation while valid is low.
// Modports:
//   master : the requester (drives commands, consumes responses)
//   slave  : the port client (accepts commands, produces responses)
interface dpram_port_client_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [AW-1:0]         req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/dpram_rsp_fifo.sv
// dpram_rsp_fifo: small synchronous FIFO for response data.
//   clk, rst_n      : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : write an entry at the tail
//   pop, pop_data   : remove the head entry; pop_data is the head, 0 when empty
//   empty, count    : occupancy status
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// Simultaneous push and pop keep the count unchanged and preserve order.
module dpram_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full;
    logic                  pop_ok;
    logic                  push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Upstream flow control must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop_ok))
        else $error("dpram_rsp_fifo: push while full");

endmodule

// File: rtl/dpram_port_client.sv
// dpram_port_client: initiator side of one DPRAM port.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : command channel in, response channel out
//   ram_en/ram_wr/ram_addr/ram_wdata : DPRAM port pins (wr: 1 = read, 0 = write)
//   ram_rdata      : DPRAM read data, valid one cycle after a read enable
// Commands drive the RAM pins combinationally in their accept cycle. Read data
// is captured one cycle later into a response FIFO. Credits (in-flight read
// plus buffered entries) gate req_ready, so the FIFO never overflows and
// req_ready never depends on rsp_ready or req_valid.
// Build option: define DPRAM_CLIENT_WACK_EN to make each accepted write return
// a response with data 0, ordered with reads and consuming a credit.
module dpram_port_client
    import dpram_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 1024,
    parameter int  RSP_DEPTH  = 3,
    localparam int AW         = addr_width(DEPTH),
    localparam int CW         = $clog2(RSP_DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    dpram_port_client_if.slave     bus,
    output logic                   ram_en,
    output logic                   ram_wr,
    output logic [AW-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    input  logic [DATA_WIDTH-1:0]  ram_rdata
);

    logic                  fire;
    logic                  inflight_q, inflight_d;
    // Set when the in-flight slot holds a write ack rather than a read.
    logic                  inflight_wr_q, inflight_wr_d;
    logic [CW-1:0]         rsp_count;
    logic [CW:0]           used;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;

    assign used          = (CW+1)'(inflight_q) + (CW+1)'(rsp_count);
    assign bus.req_ready = reset_n && (used < (CW+1)'(RSP_DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;

    // Pins are idle-zero so the RAM sees nothing outside an accept cycle.
    assign ram_en    = fire;
    assign ram_wr    = fire ? (bus.req_write ? RAM_OP_WRITE : RAM_OP_READ) : 1'b0;
    assign ram_addr  = fire ? bus.req_addr  : '0;
    assign ram_wdata = fire ? bus.req_wdata : '0;

    always_comb begin
        inflight_d    = 1'b0;
        inflight_wr_d = 1'b0;
`ifdef DPRAM_CLIENT_WACK_EN
        inflight_d    = fire;
        inflight_wr_d = fire && bus.req_write;
`else
        inflight_d    = fire && !bus.req_write;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_wr_q <= inflight_wr_d;
        end
    end

    // ram_rdata only matters while a read is in flight; a write ack carries 0.
    assign push_data     = inflight_wr_q ? '0 : ram_rdata;
    assign bus.rsp_valid = !fifo_empty;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    dpram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .push      (inflight_q),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (bus.rsp_data),
        .empty     (fifo_empty),
        .count     (rsp_count)
    );

endmodule
